// File: rtl/register_dump_reader_pkg.sv
// Shared processor definitions: register file geometry, data width and the
// state encoding used by the register dump reader.
package register_dump_reader_pkg;

  localparam int NUM_REGS       = 32;
  localparam int REG_ADDR_WIDTH = $clog2(NUM_REGS);
  localparam int XLEN           = 64;

  typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]           reg_data_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    SEND    = 2'd2,
    DONE    = 2'd3
  } dump_state_t;

  function automatic reg_addr_t next_index(input reg_addr_t current);
    return current + reg_addr_t'(1);
  endfunction

endpackage

// File: rtl/register_dump_reader_regfile.sv
// Integer register file: two combinational read ports, one synchronous write
// port, x0 hardwired to zero.
module register_file
  import register_dump_reader_pkg::*;
(
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_address,
  output logic [XLEN-1:0]           rs1_data,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_address,
  output logic [XLEN-1:0]           rs2_data,
  input  logic                      write_enable,
  input  logic [REG_ADDR_WIDTH-1:0] write_address,
  input  logic [XLEN-1:0]           write_data
);

  logic [XLEN-1:0] regs [NUM_REGS];

  // Writes land on the clock edge, so a read in the same cycle sees the old value.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (write_enable && (write_address != '0)) begin
      regs[write_address] <= write_data;
    end
  end

  assign rs1_data = regs[rs1_address];
  assign rs2_data = regs[rs2_address];

endmodule

// File: rtl/register_dump_reader.sv
// Walks a range of the register file through one read port and streams each
// register out as a valid/ready record, pulsing done after the last is accepted.
module register_dump_reader
  import register_dump_reader_pkg::*;
#(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic                      abort,
  output logic [REG_ADDR_WIDTH-1:0] rf_read_address,
  input  logic [XLEN-1:0]           rf_read_data,
  output logic                      dump_valid,
  input  logic                      dump_ready,
  output logic [REG_ADDR_WIDTH-1:0] dump_address,
  output logic [XLEN-1:0]           dump_data,
  output logic                      busy,
  output logic                      done
);

  localparam reg_addr_t FIRST_INDEX = reg_addr_t'(FIRST_REG);
  localparam reg_addr_t LAST_INDEX  = reg_addr_t'(LAST_REG);

  dump_state_t state;
  reg_addr_t   index;
  logic        accepted;
  logic        at_last;

  // The read port follows the index directly so it only moves when a record advances.
  assign rf_read_address = index;
  assign accepted        = dump_valid & dump_ready;
  assign at_last         = (index == LAST_INDEX);

  // Termination is by comparison against LAST_INDEX, so a 5-bit index never wraps.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      index        <= FIRST_INDEX;
      dump_valid   <= 1'b0;
      dump_address <= '0;
      dump_data    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else if (abort && (state != IDLE)) begin
      state      <= IDLE;
      index      <= FIRST_INDEX;
      dump_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            index <= FIRST_INDEX;
            busy  <= 1'b1;
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          dump_data    <= rf_read_data;
          dump_address <= index;
          dump_valid   <= 1'b1;
          state        <= SEND;
        end
        SEND: begin
          if (accepted) begin
            dump_valid <= 1'b0;
            if (at_last) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              index <= next_index(index);
              state <= CAPTURE;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          index <= FIRST_INDEX;
          state <= IDLE;
        end
        default: begin
          state      <= IDLE;
          index      <= FIRST_INDEX;
          dump_valid <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/register_dump_reader.md
REGISTER_DUMP_READER -- requirements
Module: register_dump_reader

Interface
REQ-001 Parameter FIRST_REG, default 0, first register index dumped.
REQ-002 Parameter LAST_REG, default 31, last register index dumped; FIRST_REG <= LAST_REG <= 31.
REQ-003 clock  input  1  single system clock; all state on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request a dump; sampled only in IDLE.
REQ-006 abort  input  1  cancel an in-progress dump.
REQ-007 rf_read_address  output  5  address driven to one register file read port (rs1 or rs2).
REQ-008 rf_read_data  input  64  combinational read data returned by the register file for rf_read_address.
REQ-009 dump_valid  output  1  dump_address/dump_data hold a valid record.
REQ-010 dump_ready  input  1  sink accepts the record when high with dump_valid.
REQ-011 dump_address  output  5  register index of the current record.
REQ-012 dump_data  output  64  captured register value.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse after the LAST_REG record is accepted.

Function
REQ-015 The FSM SHALL have states IDLE, CAPTURE, SEND, and DONE.
REQ-016 In IDLE, start=1 loads index=FIRST_REG and moves to CAPTURE next cycle; start=0 stays in IDLE.
REQ-017 In CAPTURE, rf_read_address=index; at the clock edge dump_data<=rf_read_data, dump_address<=index, dump_valid<=1, and the FSM moves to SEND.
REQ-018 In SEND, outputs SHALL hold stable while dump_ready=0; dump_valid SHALL never drop without a handshake or abort.
REQ-019 On SEND handshake (dump_valid&dump_ready): dump_valid<=0; if index==LAST_REG go DONE, else index<=index+1 and go CAPTURE.
REQ-020 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-021 Throughput SHALL be one record per 2 cycles with dump_ready held high; a full 0..31 dump completes with done asserted 65 cycles after start is sampled.
REQ-022 x0 SHALL be dumped as whatever the register file returns (expected 0); no special-casing.
REQ-023 If a register write to index occurs on the CAPTURE edge, the captured value SHALL be the pre-write value; no cross-register snapshot consistency is provided.
REQ-024 start while busy SHALL be ignored.
REQ-025 abort=1 in any non-IDLE state SHALL force IDLE on the next edge with dump_valid=0 and no done pulse; abort has priority over handshake; abort in IDLE is ignored.
REQ-026 rf_read_address SHALL equal index in all states (FIRST_REG in IDLE) to avoid spurious toggling.
REQ-027 The index counter SHALL be 5 bits; LAST_REG=31 terminates by comparison, never by wrap-around.

Reset
REQ-028 reset_n=0 SHALL immediately force IDLE, index=FIRST_REG, dump_valid=0, dump_address=0, dump_data=0, busy=0, done=0.
REQ-029 Reset asserted mid-dump SHALL discard the dump with no done pulse; the first start after reset release begins again at FIRST_REG.

Structure
REQ-030 The state encoding and the register-count constant (32) and data width (64) SHALL live in the shared processor package used by register_file.
REQ-031 The block SHALL be a single module with no sub-modules; the bench instantiates it with a real register_file.

Verification
REQ-032 Preload x5=0x1111, x31=0xFFFFFFFFFFFFFFFF, start with dump_ready=1 -> 32 records addr 0..31, x0 data 0, addr 5 data 0x1111, addr 31 data all-ones, done 65 cycles after start.
REQ-033 dump_ready low for 3 cycles on record 10 (x10=0xAAAA) -> dump_valid/dump_address/dump_data held stable 3 cycles, then accepted; no record lost or duplicated.
REQ-034 abort asserted during SEND of record 7 -> next cycle IDLE, dump_valid=0, busy=0, no done; new start dumps from 0.
REQ-035 reset_n pulsed low during CAPTURE of record 12 -> outputs zero asynchronously, no done; post-reset start dumps all 32.
REQ-036 Writeback writes x3=0x3333 on the CAPTURE edge of record 3 (old 0x0) -> record 3 data 0x0; a second dump shows 0x3333.
REQ-037 FIRST_REG=10, LAST_REG=11, start pulsed again while busy -> exactly 2 records (0xAAAA, 0xBBBB), single done, second start ignored.
